ps2_key_tracker: RTL and testbench

- Parametrised PS/2 scancode-set-2 decoder. It sits between PS2_Controller (received_data / received_data_en) and game logic.
- Tracks the make/break state of NUM_KEYS configurable keys, including E0-extended keys.
- Emits a held-key bitmask, one-cycle press/release pulses, and a 2-bit accel command from two designated keys.
- Generalises the single-key forward/backward break-point decoder to N keys, with a recency rule when both directions are held and a prefix timeout.

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_prefix_timer.sv | 41 ++++
 rtl/ps2_key_tracker.sv | 122 ++++++++++++
 tb/tb_ps2_key_tracker.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and encodings for the PS/2 scancode-set-2 key tracker.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_t;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } ps2_dir_t;

  localparam logic [1:0] ACC_NONE = 2'b00;
  localparam logic [1:0] ACC_FWD  = 2'b10;
  localparam logic [1:0] ACC_REV  = 2'b01;

endpackage

// File: rtl/ps2_prefix_timer.sv
// Idle-cycle watchdog for a partially received prefix sequence.
// expire is high in the cycle the count would reach TIMEOUT_CYCLES-1 with no clear.
module ps2_prefix_timer #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 2);

  logic [CW-1:0] count_r;

  // Expiry detect: a clear in the same cycle always suppresses it.
  always_comb begin
    expire = 1'b0;
    if (enable && !clear && (count_r == LAST_COUNT)) begin
      expire = 1'b1;
    end else begin
      expire = 1'b0;
    end
  end

  // Idle counter, restarted by any clear or by its own expiry.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      count_r <= {CW{1'b0}};
    end else if (clear || expire) begin
      count_r <= {CW{1'b0}};
    end else if (enable) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 decoder tracking make/break state of NUM_KEYS keys (E0-aware),
// with press/release pulses and a recency-resolved forward/reverse accel command.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int                        NUM_KEYS       = 4,
  parameter logic [8*NUM_KEYS-1:0]     KEY_CODES      = {8'h74, 8'h6B, 8'h72, 8'h73},
  parameter logic [NUM_KEYS-1:0]       KEY_EXT        = 4'b0000,
  parameter int                        FWD_IDX        = 0,
  parameter int                        REV_IDX        = 1,
  parameter int                        TIMEOUT_CYCLES = 50000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [7:0]          ps2_data,
  input  logic                ps2_data_en,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [1:0]          accel,
  output logic                protocol_err
);

  ps2_state_t          state_r, state_s;
  ps2_dir_t            dir_r, dir_s;
  logic                make_s, brk_s, ext_s, err_s, expire_s;
  logic [NUM_KEYS-1:0] match_s, hit_s, held_s, press_s, release_s;
  logic [1:0]          accel_s;

  ps2_prefix_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .clear    (ps2_data_en || (state_r == ST_IDLE)),
    .enable   (state_r != ST_IDLE),
    .expire   (expire_s)
  );

  // Prefix FSM: classifies each byte as make/break (plain or extended) or error.
  always_comb begin
    state_s = state_r;
    make_s  = 1'b0;
    brk_s   = 1'b0;
    ext_s   = 1'b0;
    err_s   = 1'b0;
    if (ps2_data_en) begin
      case (state_r)
        ST_IDLE: begin
          if (ps2_data == PS2_EXT)      state_s = ST_EXT;
          else if (ps2_data == PS2_BRK) state_s = ST_BRK;
          else                          make_s  = 1'b1;
        end
        ST_EXT: begin
          if (ps2_data == PS2_BRK) begin
            state_s = ST_EXT_BRK;
          end else if (ps2_data == PS2_EXT) begin
            err_s = 1'b1;
          end else begin
            make_s  = 1'b1;
            ext_s   = 1'b1;
            state_s = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          state_s = ST_IDLE;
          ext_s   = (state_r == ST_EXT_BRK);
          if ((ps2_data == PS2_BRK) || (ps2_data == PS2_EXT)) err_s = 1'b1;
          else                                                brk_s = 1'b1;
        end
        default: state_s = ST_IDLE;
      endcase
    end else if (expire_s) begin
      err_s   = 1'b1;
      state_s = ST_IDLE;
    end else begin
      state_s = state_r;
    end
  end

  // Per-key match; the lowest-index match is isolated below.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    assign match_s[i]   = (ps2_data == KEY_CODES[8*i +: 8]) && (ext_s == KEY_EXT[i]);
    assign held_s[i]    = (hit_s[i] && make_s) ? 1'b1 :
                          (hit_s[i] && brk_s)  ? 1'b0 : key_held[i];
    assign press_s[i]   = hit_s[i] && make_s && !key_held[i];
    assign release_s[i] = hit_s[i] && brk_s && key_held[i];
  end

  assign hit_s = match_s & (~match_s + NUM_KEYS'(1));

  // Direction recency and accel command, from next-state held bits.
  always_comb begin
    dir_s = dir_r;
    if (make_s && hit_s[FWD_IDX])      dir_s = DIR_FWD;
    else if (make_s && hit_s[REV_IDX]) dir_s = DIR_REV;
    else                               dir_s = dir_r;
    if (held_s[FWD_IDX] && (!held_s[REV_IDX] || (dir_s == DIR_FWD)))      accel_s = ACC_FWD;
    else if (held_s[REV_IDX] && (!held_s[FWD_IDX] || (dir_s == DIR_REV))) accel_s = ACC_REV;
    else                                                                 accel_s = ACC_NONE;
  end

  // Output and state registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      dir_r        <= DIR_FWD;
      key_held     <= {NUM_KEYS{1'b0}};
      key_press    <= {NUM_KEYS{1'b0}};
      key_release  <= {NUM_KEYS{1'b0}};
      accel        <= ACC_NONE;
      protocol_err <= 1'b0;
    end else begin
      state_r      <= state_s;
      dir_r        <= dir_s;
      key_held     <= held_s;
      key_press    <= press_s;
      key_release  <= release_s;
      accel        <= accel_s;
      protocol_err <= err_s;
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: a behavioural model queues the expected
// outputs for every driven cycle and they are compared after the clock edge.
module tb_ps2_key_tracker;

  localparam int TO = 16;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b0;
  logic [7:0]  ps2_data = 8'h00;
  logic        ps2_data_en = 1'b0;
  logic [3:0]  key_held, key_press, key_release;
  logic [1:0]  accel;
  logic        protocol_err;

  ps2_key_tracker #(
    .KEY_EXT        (4'b0100),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .ps2_data     (ps2_data),
    .ps2_data_en  (ps2_data_en),
    .key_held     (key_held),
    .key_press    (key_press),
    .key_release  (key_release),
    .accel        (accel),
    .protocol_err (protocol_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [3:0] held;
    logic [3:0] press;
    logic [3:0] rel;
    logic [1:0] acc;
    logic       err;
  } exp_t;

  exp_t       exp_q[$];
  int         tests_run    = 0;
  int         tests_failed = 0;

  logic [7:0] codes [4] = '{8'h73, 8'h72, 8'h6B, 8'h74};
  logic [3:0] ext_mask  = 4'b0100;
  int         m_st   = 0;
  int         m_cnt  = 0;
  logic [3:0] m_held = 4'b0000;
  logic       m_dir  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model(input logic rst, input logic v, input logic [7:0] b, output exp_t e);
    logic mk, bk, x;
    int   hit;
    e = '0; mk = 1'b0; bk = 1'b0; x = 1'b0;
    if (rst) begin
      m_st = 0; m_cnt = 0; m_held = 4'b0000; m_dir = 1'b0;
    end else if (v) begin
      m_cnt = 0;
      case (m_st)
        0: if (b == 8'hE0) m_st = 1; else if (b == 8'hF0) m_st = 2; else mk = 1'b1;
        1: if (b == 8'hF0) m_st = 3;
           else if (b == 8'hE0) e.err = 1'b1;
           else begin mk = 1'b1; x = 1'b1; m_st = 0; end
        default: begin
          x = (m_st == 3);
          m_st = 0;
          if (b == 8'hF0 || b == 8'hE0) e.err = 1'b1; else bk = 1'b1;
        end
      endcase
    end else if (m_st != 0) begin
      if (m_cnt == TO - 2) begin e.err = 1'b1; m_st = 0; m_cnt = 0; end
      else m_cnt++;
    end
    hit = -1;
    for (int i = 0; i < 4; i++)
      if (hit < 0 && codes[i] == b && ext_mask[i] == x) hit = i;
    if (hit >= 0 && mk) begin
      if (!m_held[hit]) e.press[hit] = 1'b1;
      m_held[hit] = 1'b1;
      if (hit == 0) m_dir = 1'b0;
      if (hit == 1) m_dir = 1'b1;
    end
    if (hit >= 0 && bk && m_held[hit]) begin
      e.rel[hit] = 1'b1;
      m_held[hit] = 1'b0;
    end
    e.held = m_held;
    if (m_held[0] && (!m_held[1] || m_dir == 1'b0))      e.acc = 2'b10;
    else if (m_held[1] && (!m_held[0] || m_dir == 1'b1)) e.acc = 2'b01;
    else                                                 e.acc = 2'b00;
  endtask

  task automatic step(input logic rst, input logic v, input logic [7:0] b);
    exp_t e;
    @(negedge CLOCK_50);
    reset = rst; ps2_data_en = v; ps2_data = b;
    model(rst, v, b, e);
    exp_q.push_back(e);
    @(posedge CLOCK_50);
    #1;
    reset = 1'b0; ps2_data_en = 1'b0;
    e = exp_q.pop_front();
    check_eq("key_held",     {28'd0, key_held},     {28'd0, e.held});
    check_eq("key_press",    {28'd0, key_press},    {28'd0, e.press});
    check_eq("key_release",  {28'd0, key_release},  {28'd0, e.rel});
    check_eq("accel",        {30'd0, accel},        {30'd0, e.acc});
    check_eq("protocol_err", {31'd0, protocol_err}, {31'd0, e.err});
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b0, 1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int n;
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    check_eq("reset_held",  {28'd0, key_held}, 32'd0);
    check_eq("reset_accel", {30'd0, accel},    32'd0);

    // single forward key press/release
    send(8'h73); idle(2); send(8'hF0); send(8'h73); idle(1);
    // typematic repeat on reverse key
    send(8'h72); send(8'h72); send(8'h72); idle(1); send(8'hF0); send(8'h72);
    // both directions held, recency decides
    send(8'h73); send(8'h72); send(8'hF0); send(8'h72); send(8'h72);
    send(8'hF0); send(8'h72); send(8'hF0); send(8'h73);
    // extended key: bare 6B ignored, E0 6B held, plain break ignored
    send(8'h6B); send(8'hE0); send(8'h6B); send(8'hF0); send(8'h6B); idle(1);
    check_eq("ext_held_after_plain_break", {31'd0, key_held[2]}, 32'd1);
    send(8'hE0); send(8'hF0); send(8'h6B);
    // repeated E0 is an error but stays extended
    send(8'hE0); send(8'hE0); send(8'h6B); send(8'hE0); send(8'hF0); send(8'h6B);
    // unmatched code and break of an unheld key
    send(8'h1C); send(8'hF0); send(8'h74);

    // prefix timeout
    send(8'hF0);
    n = 0;
    do begin
      idle(1);
      n++;
    end while (!protocol_err && n < 30);
    check_eq("timeout_cycle", n, 32'd15);
    send(8'h73); send(8'hF0); send(8'h73);
    // strobe on the expiry cycle wins
    send(8'hE0); idle(TO - 2); send(8'h6B); send(8'hE0); send(8'hF0); send(8'h6B);

    // illegal prefix, then reset drops held keys
    send(8'hF0); send(8'hF0); send(8'h73);
    step(1'b1, 1'b0, 8'h00);
    send(8'hF0); send(8'h73); idle(2);
    send(8'hE0); step(1'b1, 1'b0, 8'h00); send(8'h6B); idle(1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
